// File: rtl/l2_read_hit_pipe.sv
// l2_read_hit_pipe
// Registered L2 read-hit data select. Picks the lowest-index hitting way,
// optionally extracts one aligned 32-bit word, and queues the result in a
// 2-entry response buffer with valid/ready handshakes. Keeps saturating
// hit/miss statistics over accepted requests.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready depends on registered state only)
//   way_hit           per-way hit flags, bit i = way i
//   way_data          way i line at [i*LINE_W +: LINE_W]
//   offset            byte offset into line (word select in word mode)
//   word_mode         0 = full line, 1 = zero-extended aligned 32-bit word
//   resp_valid/ready  response handshake, head of the buffer
//   resp_data         selected line or word
//   resp_miss         no way hit
//   resp_multihit     more than one way hit
//   stats_clr         synchronous clear of both counters (wins over accept)
//   hit_count         saturating count of accepted hits (multihit included)
//   miss_count        saturating count of accepted misses
module l2_read_hit_pipe #(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned OFF_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WAYS-1:0]          way_hit,
  input  logic [WAYS*LINE_W-1:0]   way_data,
  input  logic [OFF_W-1:0]         offset,
  input  logic                     word_mode,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [LINE_W-1:0]        resp_data,
  output logic                     resp_miss,
  output logic                     resp_multihit,
  input  logic                     stats_clr,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         miss_count
);

  localparam int unsigned WORDS = LINE_W / 32;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              miss;
    logic              multihit;
  } entry_t;

  // Buffer storage: r_head is always the oldest entry
  entry_t       r_head;
  entry_t       r_tail;
  logic [1:0]   r_count;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic              w_found;
  logic              w_multi;
  logic [LINE_W-1:0] w_hit_line;
  logic [31:0]       w_word;
  logic [31:0]       w_word_idx;
  entry_t            w_new;
  logic              w_push;
  logic              w_pop;

  // Lowest-index hit wins; a second hit seen after the first flags multihit
  always_comb begin
    w_found    = 1'b0;
    w_multi    = 1'b0;
    w_hit_line = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (way_hit[i]) begin
        if (w_found) begin
          w_multi = 1'b1;
        end else begin
          w_found    = 1'b1;
          w_hit_line = way_data[i*LINE_W +: LINE_W];
        end
      end
    end
  end

  // Word index comes from offset above the byte-in-word bits
  assign w_word_idx = 32'(offset >> 2);

  always_comb begin
    w_word = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (w_word_idx == w) begin
        w_word = w_hit_line[w*32 +: 32];
      end
    end
  end

  // A miss leaves w_hit_line at zero, so both modes return zero data
  always_comb begin
    w_new          = '0;
    w_new.data     = word_mode ? LINE_W'(w_word) : w_hit_line;
    w_new.miss     = ~w_found;
    w_new.multihit = w_multi;
  end

  assign req_ready = (r_count != 2'd2);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_count != 2'd0) && resp_ready;

  // Two-entry FIFO; push+pop is only possible at occupancy 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= w_new;
          else                 r_tail <= w_new;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          r_head <= w_new;
        end
        default: ;
      endcase
    end
  end

  // Saturating statistics; clear takes priority over a same-edge accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (stats_clr) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_push) begin
      if (w_found) begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end else begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

  assign resp_valid    = (r_count != 2'd0);
  assign resp_data     = r_head.data;
  assign resp_miss     = r_head.miss;
  assign resp_multihit = r_head.multihit;
  assign hit_count     = r_hit_cnt;
  assign miss_count    = r_miss_cnt;

endmodule

// File: tb/tb_l2_read_hit_pipe.sv
// Self-checking bench for l2_read_hit_pipe: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference.
module tb_l2_read_hit_pipe;

  localparam int unsigned WAYS   = 2;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned OFF_W  = 5;
  localparam int unsigned CNT_W  = 2;
  localparam int          CMAX   = 3;

  logic                   clk;
  logic                   rst_n;
  logic                   req_valid;
  logic                   req_ready;
  logic [WAYS-1:0]        way_hit;
  logic [WAYS*LINE_W-1:0] way_data;
  logic [OFF_W-1:0]       offset;
  logic                   word_mode;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [LINE_W-1:0]      resp_data;
  logic                   resp_miss;
  logic                   resp_multihit;
  logic                   stats_clr;
  logic [CNT_W-1:0]       hit_count;
  logic [CNT_W-1:0]       miss_count;

  l2_read_hit_pipe #(
    .WAYS(WAYS), .LINE_W(LINE_W), .OFF_W(OFF_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .way_hit(way_hit), .way_data(way_data),
    .offset(offset), .word_mode(word_mode),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_miss(resp_miss), .resp_multihit(resp_multihit),
    .stats_clr(stats_clr), .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LINE_W-1:0] d;
    logic              miss;
    logic              mh;
  } ent_t;

  ent_t exp_q[$];
  int   m_hit;
  int   m_miss;
  int   tests;
  int   fails;

  task automatic chk(input string name, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference selection from the rules: first hit way's line, count of hits
  function automatic ent_t model_entry(input logic [WAYS-1:0] hit,
                                       input logic [WAYS*LINE_W-1:0] data,
                                       input logic [OFF_W-1:0] off,
                                       input logic wm);
    ent_t e;
    logic [LINE_W-1:0] line;
    int n;
    line = '0;
    n = 0;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (hit[i]) begin
        n++;
        if (n == 1) line = data[i*LINE_W +: LINE_W];
      end
    end
    e.miss = (n == 0);
    e.mh   = (n > 1);
    if (wm) e.d = (line >> (32 * (int'(off) / 4))) & 256'hFFFFFFFF;
    else    e.d = line;
    return e;
  endfunction

  task automatic model_step();
    bit acc;
    bit pop;
    acc = req_valid && (exp_q.size() < 2);
    pop = (exp_q.size() != 0) && resp_ready;
    if (pop) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(model_entry(way_hit, way_data, offset, word_mode));
    if (stats_clr) begin
      m_hit = 0;
      m_miss = 0;
    end else if (acc) begin
      if (way_hit != '0) m_hit  = (m_hit  < CMAX) ? m_hit + 1  : CMAX;
      else               m_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
    end
  endtask

  task automatic compare();
    chk("resp_valid", LINE_W'(resp_valid), LINE_W'(exp_q.size() != 0));
    chk("req_ready", LINE_W'(req_ready), LINE_W'(exp_q.size() < 2));
    chk("hit_count", LINE_W'(hit_count), LINE_W'(m_hit));
    chk("miss_count", LINE_W'(miss_count), LINE_W'(m_miss));
    if (exp_q.size() != 0) begin
      chk("resp_data", resp_data, exp_q[0].d);
      chk("resp_miss", LINE_W'(resp_miss), LINE_W'(exp_q[0].miss));
      chk("resp_multihit", LINE_W'(resp_multihit), LINE_W'(exp_q[0].mh));
    end
  endtask

  // One clock: model follows the edge, DUT checked on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic set_req(input logic v, input logic [WAYS-1:0] hit,
                         input logic [LINE_W-1:0] l0, input logic [LINE_W-1:0] l1,
                         input logic [OFF_W-1:0] off, input logic wm);
    req_valid = v;
    way_hit   = hit;
    way_data  = {l1, l0};
    offset    = off;
    word_mode = wm;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int w = 0; w < int'(LINE_W / 32); w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  logic [LINE_W-1:0] a5_line;
  logic [LINE_W-1:0] l0;
  logic [LINE_W-1:0] bp_line [3];

  initial begin
    tests = 0; fails = 0; m_hit = 0; m_miss = 0;
    rst_n = 1'b0; resp_ready = 1'b1; stats_clr = 1'b0;
    set_req(1'b0, '0, '0, '0, '0, 1'b0);
    a5_line = {32{8'hA5}};

    // Reset values while held in reset
    repeat (2) @(negedge clk);
    chk("rst resp_valid", LINE_W'(resp_valid), '0);
    chk("rst resp_data", resp_data, '0);
    chk("rst resp_miss", LINE_W'(resp_miss), '0);
    chk("rst resp_multihit", LINE_W'(resp_multihit), '0);
    chk("rst hit_count", LINE_W'(hit_count), '0);
    chk("rst miss_count", LINE_W'(miss_count), '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst req_ready", LINE_W'(req_ready), LINE_W'(1));

    // Hit in way 1 only, full line
    set_req(1'b1, 2'b10, {8{32'h0BADF00D}}, a5_line, 5'd3, 1'b0);
    cycle();
    chk("way1 resp_valid", LINE_W'(resp_valid), LINE_W'(1));
    chk("way1 resp_data", resp_data, a5_line);
    chk("way1 resp_miss", LINE_W'(resp_miss), '0);
    chk("way1 hit_count", LINE_W'(hit_count), LINE_W'(1));

    // Word mode, way 0 word 7
    l0 = {8{32'h11111111}};
    l0[255:224] = 32'hDEADBEEF;
    set_req(1'b1, 2'b01, l0, a5_line, 5'd28, 1'b1);
    cycle();
    chk("word resp_data", resp_data, 256'hDEADBEEF);

    // Clear, then miss followed by multihit
    set_req(1'b0, '0, '0, '0, '0, 1'b0);
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    set_req(1'b1, 2'b00, l0, a5_line, 5'd0, 1'b0);
    cycle();
    chk("miss resp_miss", LINE_W'(resp_miss), LINE_W'(1));
    chk("miss resp_data", resp_data, '0);
    chk("miss miss_count", LINE_W'(miss_count), LINE_W'(1));
    set_req(1'b1, 2'b11, l0, a5_line, 5'd0, 1'b0);
    cycle();
    chk("mh resp_multihit", LINE_W'(resp_multihit), LINE_W'(1));
    chk("mh resp_data", resp_data, l0);
    chk("mh hit_count", LINE_W'(hit_count), LINE_W'(1));
    set_req(1'b0, '0, '0, '0, '0, 1'b0);
    cycle();

    // Back-pressure: three back-to-back requests into a stalled buffer
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bp_line[k] = {8{32'(k + 32'h100)}};
      set_req(1'b1, 2'b01, bp_line[k], '0, '0, 1'b0);
      cycle();
    end
    chk("bp req_ready", LINE_W'(req_ready), '0);
    chk("bp head0", resp_data, bp_line[0]);
    resp_ready = 1'b1;
    cycle();
    chk("bp head1", resp_data, bp_line[1]);
    cycle();
    chk("bp head2", resp_data, bp_line[2]);
    set_req(1'b0, '0, '0, '0, '0, 1'b0);
    cycle();
    chk("bp drained", LINE_W'(resp_valid), '0);

    // Saturation at 2^CNT_W-1, then clear beats a same-edge hit
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_req(1'b1, 2'b10, '0, rand_line(), '0, 1'b0);
      cycle();
    end
    chk("sat hit_count", LINE_W'(hit_count), LINE_W'(3));
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    chk("clr hit_count", LINE_W'(hit_count), '0);

    // Async reset with the buffer full
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, 2'b01, rand_line(), '0, '0, 1'b0);
      cycle();
    end
    chk("full req_ready", LINE_W'(req_ready), '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst resp_valid", LINE_W'(resp_valid), '0);
    chk("arst hit_count", LINE_W'(hit_count), '0);
    chk("arst miss_count", LINE_W'(miss_count), '0);
    exp_q.delete();
    m_hit = 0;
    m_miss = 0;
    set_req(1'b0, '0, '0, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst req_ready", LINE_W'(req_ready), LINE_W'(1));
    compare();

    // Randomized traffic against the reference
    for (int c = 0; c < 1500; c++) begin
      set_req(($urandom % 4) != 0, WAYS'($urandom), rand_line(), rand_line(),
              OFF_W'($urandom), 1'($urandom));
      resp_ready = ($urandom % 3) != 0;
      stats_clr  = ($urandom % 16) == 0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
